// File: rtl/bus_dev_endpoint_if.sv
// Bus-side signals of one driver slot: the TX head offered to the bus
// (pndng/D_pop/pop) and the packet delivered by the bus (push/D_push).
interface bus_dev_endpoint_if #(
    parameter int pckg_sz = 16
);
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    logic               push;
    logic [pckg_sz-1:0] D_push;

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );
endinterface

// File: rtl/bus_dev_endpoint.sv
// Device-side endpoint for one bus slot: a first-word-fall-through TX FIFO
// drained by the bus and an ID-filtered first-word-fall-through RX FIFO.
module bus_dev_endpoint #(
    parameter int          pckg_sz   = 16,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    bus_dev_endpoint_if.slave  bus,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_vld,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [7:0]         rx_drop_cnt
);
    localparam int              aw       = $clog2(depth);
    localparam logic [aw:0]     full_cnt = (aw + 1)'(depth);
    localparam logic [aw:0]     cnt_one  = (aw + 1)'(1);
    localparam logic [aw-1:0]   ptr_one  = aw'(1);

    // Handshake: pndng/rx_vld act as "valid", pop/rx_rd as "ready"; a head
    // entry moves only on an edge where both are high. pop or rx_rd with the
    // FIFO empty is ignored, and a full FIFO still accepts a new entry when
    // its head leaves in the same cycle.

    logic [pckg_sz-1:0] tx_mem [depth];
    logic [aw-1:0]      tx_wp, tx_rp;
    logic [aw:0]        tx_cnt;
    logic               tx_do_wr, tx_do_rd;

    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      rx_wp, rx_rp;
    logic [aw:0]        rx_cnt;
    logic               rx_do_wr, rx_do_rd, rx_match, rx_drop;

    always_comb begin
        tx_do_rd = bus.pop && (tx_cnt != '0);
        tx_do_wr = tx_wr && ((tx_cnt != full_cnt) || tx_do_rd);
        rx_do_rd = rx_rd && (rx_cnt != '0);
        rx_match = (bus.D_push[pckg_sz-1 -: 8] == id) ||
                   (bus.D_push[pckg_sz-1 -: 8] == broadcast);
        rx_do_wr = bus.push && rx_match && ((rx_cnt != full_cnt) || rx_do_rd);
        rx_drop  = bus.push && !rx_do_wr;
    end

    always_ff @(posedge clk) begin
        if (tx_do_wr) tx_mem[tx_wp] <= tx_data;
        if (rx_do_wr) rx_mem[rx_wp] <= bus.D_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (tx_do_wr) tx_wp <= tx_wp + ptr_one;
            if (tx_do_rd) tx_rp <= tx_rp + ptr_one;
            case ({tx_do_wr, tx_do_rd})
                2'b10:   tx_cnt <= tx_cnt + cnt_one;
                2'b01:   tx_cnt <= tx_cnt - cnt_one;
                default: tx_cnt <= tx_cnt;
            endcase
            if (tx_wr && !tx_do_wr) tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wp       <= '0;
            rx_rp       <= '0;
            rx_cnt      <= '0;
            rx_ovf      <= 1'b0;
            rx_drop_cnt <= 8'd0;
        end else begin
            if (rx_do_wr) rx_wp <= rx_wp + ptr_one;
            if (rx_do_rd) rx_rp <= rx_rp + ptr_one;
            case ({rx_do_wr, rx_do_rd})
                2'b10:   rx_cnt <= rx_cnt + cnt_one;
                2'b01:   rx_cnt <= rx_cnt - cnt_one;
                default: rx_cnt <= rx_cnt;
            endcase
            if (bus.push && rx_match && !rx_do_wr) rx_ovf <= 1'b1;
            if (rx_drop && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
        end
    end

    // Head outputs are forced to zero while empty so stale storage never leaks.
    always_comb begin
        bus.pndng = (tx_cnt != '0);
        bus.D_pop = bus.pndng ? tx_mem[tx_rp] : '0;
        tx_full   = (tx_cnt == full_cnt);
        rx_vld    = (rx_cnt != '0);
        rx_data   = rx_vld ? rx_mem[rx_rp] : '0;
    end
endmodule

// File: tb/tb_bus_dev_endpoint.sv
// Directed bench for bus_dev_endpoint (id=2): TX/RX ordering, full and
// overflow handling, ID filtering, async reset and drop-counter saturation.
module tb_bus_dev_endpoint;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         tx_wr;
    logic [W-1:0] tx_data;
    logic         tx_full;
    logic         rx_rd;
    logic [W-1:0] rx_data;
    logic         rx_vld;
    logic         tx_ovf;
    logic         rx_ovf;
    logic [7:0]   rx_drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    bus_dev_endpoint_if #(.pckg_sz(W)) bus ();

    bus_dev_endpoint #(
        .pckg_sz(W), .depth(8), .id(8'h02), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(rst), .bus(bus.slave),
        .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_vld(rx_vld),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .rx_drop_cnt(rx_drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pndng"}, 32'(bus.pndng), 32'd0);
        check({tag, ".D_pop"}, 32'(bus.D_pop), 32'd0);
        check({tag, ".tx_full"}, 32'(tx_full), 32'd0);
        check({tag, ".rx_vld"}, 32'(rx_vld), 32'd0);
        check({tag, ".rx_data"}, 32'(rx_data), 32'd0);
        check({tag, ".tx_ovf"}, 32'(tx_ovf), 32'd0);
        check({tag, ".rx_ovf"}, 32'(rx_ovf), 32'd0);
        check({tag, ".rx_drop_cnt"}, 32'(rx_drop_cnt), 32'd0);
    endtask

    // driver tasks
    task automatic tx_write(input logic [W-1:0] d);
        tx_wr = 1'b1; tx_data = d;
        tick();
        tx_wr = 1'b0;
    endtask

    task automatic bus_push(input logic [W-1:0] d);
        bus.push = 1'b1; bus.D_push = d;
        tick();
        bus.push = 1'b0;
    endtask

    task automatic bus_pop();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic dev_read();
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
        bus.pop = 1'b0; bus.push = 1'b0; bus.D_push = '0;
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // TX ordering with one-cycle pndng latency
        tx_wr = 1'b1; tx_data = 16'h0312;
        tick();
        check("tx_first.pndng", 32'(bus.pndng), 32'd1);
        check("tx_first.D_pop", 32'(bus.D_pop), 32'h0312);
        tx_data = 16'h0456;
        tick();
        tx_wr = 1'b0;
        bus_pop();
        check("tx_pop1.D_pop", 32'(bus.D_pop), 32'h0456);
        bus_pop();
        check("tx_pop2.pndng", 32'(bus.pndng), 32'd0);
        check("tx_pop2.D_pop", 32'(bus.D_pop), 32'd0);

        // TX full, dropped write, write accepted together with pop
        for (int i = 0; i < 8; i++) tx_write(16'h0100 + 16'(i));
        check("tx_fill.full", 32'(tx_full), 32'd1);
        check("tx_fill.ovf", 32'(tx_ovf), 32'd0);
        tx_write(16'h0AAA);
        check("tx_drop.ovf", 32'(tx_ovf), 32'd1);
        check("tx_drop.head", 32'(bus.D_pop), 32'h0100);
        tx_wr = 1'b1; tx_data = 16'h0BBB; bus.pop = 1'b1;
        tick();
        tx_wr = 1'b0; bus.pop = 1'b0;
        check("tx_wr_pop.full", 32'(tx_full), 32'd1);
        check("tx_wr_pop.head", 32'(bus.D_pop), 32'h0101);
        for (int i = 1; i < 8; i++) exp_q.push_back(16'h0100 + 16'(i));
        exp_q.push_back(16'h0BBB);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("tx_drain.D_pop", 32'(bus.D_pop), 32'(exp_v));
            bus_pop();
        end
        check("tx_drain.pndng", 32'(bus.pndng), 32'd0);

        // RX filtering
        bus_push(16'h02AB);
        check("rx_match.vld", 32'(rx_vld), 32'd1);
        check("rx_match.data", 32'(rx_data), 32'h02AB);
        bus_push(16'h05CD);
        check("rx_filter.drop_cnt", 32'(rx_drop_cnt), 32'd1);
        check("rx_filter.data", 32'(rx_data), 32'h02AB);
        bus_push(16'hFF77);
        dev_read();
        check("rx_bcast.data", 32'(rx_data), 32'hFF77);
        dev_read();
        check("rx_empty.vld", 32'(rx_vld), 32'd0);
        check("rx_empty.data", 32'(rx_data), 32'd0);

        // RX full, overflow, push accepted together with read
        for (int i = 0; i < 8; i++) bus_push(16'h0200 + 16'(i));
        check("rx_fill.data", 32'(rx_data), 32'h0200);
        check("rx_fill.ovf", 32'(rx_ovf), 32'd0);
        bus_push(16'h02EE);
        check("rx_ovf.flag", 32'(rx_ovf), 32'd1);
        check("rx_ovf.drop_cnt", 32'(rx_drop_cnt), 32'd2);
        bus.push = 1'b1; bus.D_push = 16'h02DD; rx_rd = 1'b1;
        tick();
        bus.push = 1'b0; rx_rd = 1'b0;
        check("rx_push_rd.data", 32'(rx_data), 32'h0201);
        check("rx_push_rd.drop_cnt", 32'(rx_drop_cnt), 32'd2);
        for (int i = 1; i < 8; i++) exp_q.push_back(16'h0200 + 16'(i));
        exp_q.push_back(16'h02DD);
        while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check("rx_drain.rx_data", 32'(rx_data), 32'(exp_v));
            dev_read();
        end
        check("rx_drain.vld", 32'(rx_vld), 32'd0);

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0300 + 16'(i);
            bus.push = (i < 3); bus.D_push = 16'h0210 + 16'(i);
            tick();
        end
        tx_wr = 1'b0; bus.push = 1'b0;
        check("pre_rst.pndng", 32'(bus.pndng), 32'd1);
        check("pre_rst.rx_vld", 32'(rx_vld), 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("post_rst");

        // drop-counter saturation
        bus.push = 1'b1; bus.D_push = 16'h0512;
        repeat (300) tick();
        bus.push = 1'b0;
        check("sat.drop_cnt", 32'(rx_drop_cnt), 32'd255);
        check("sat.rx_vld", 32'(rx_vld), 32'd0);

        // pop / read while empty leave pointers untouched
        bus.pop = 1'b1; rx_rd = 1'b1;
        tick();
        bus.pop = 1'b0; rx_rd = 1'b0;
        check("empty_ops.pndng", 32'(bus.pndng), 32'd0);
        check("empty_ops.rx_vld", 32'(rx_vld), 32'd0);
        check("empty_ops.tx_full", 32'(tx_full), 32'd0);
        tx_wr = 1'b1; tx_data = 16'h0777;
        bus.push = 1'b1; bus.D_push = 16'h02CC;
        tick();
        tx_wr = 1'b0; bus.push = 1'b0;
        check("after_empty.D_pop", 32'(bus.D_pop), 32'h0777);
        check("after_empty.rx_data", 32'(rx_data), 32'h02CC);
        check("after_empty.drop_cnt", 32'(rx_drop_cnt), 32'd255);
        bus_pop();
        dev_read();
        check("after_empty.pndng", 32'(bus.pndng), 32'd0);
        check("after_empty.rx_vld", 32'(rx_vld), 32'd0);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
